// File: rtl/encoder_pkg.sv
// Shared constants and types for the 4-line sequential priority encoder.
// The priority-mode encoding here selects fixed or rotating search order.
package encoder_pkg;

    localparam int NUM_LINES = 4;
    localparam int CODE_W    = 2;

    typedef logic [NUM_LINES-1:0] line_vec_t;
    typedef logic [CODE_W-1:0]    code_t;

    typedef enum logic {
        PRIO_FIXED  = 1'b0,
        PRIO_ROTATE = 1'b1
    } prio_mode_e;

    // Highest line index: the fixed-mode start point and the pointer reset value.
    localparam code_t TOP_INDEX = code_t'(NUM_LINES - 1);

    function automatic line_vec_t onehot(input code_t idx);
        line_vec_t vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational picker: scans req downward from start (wrapping mod 4)
// and returns the first set index.
import encoder_pkg::*;

module prio_pick4 (
    input  line_vec_t req,
    input  code_t     start,
    output logic      found,
    output code_t     index
);

    code_t cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = start;
        for (int i = 0; i < NUM_LINES; i++) begin
            cand = start - code_t'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/encoder4_2_seq.sv
// Sequential 4:2 encoder: captures rising edges on D as pending events and
// drains them one code per cycle through a valid/ready output slot.
import encoder_pkg::*;

module encoder4_2_seq #(
    parameter int ROUND_ROBIN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] D,
    input  logic       ready,
    output logic       valid,
    output logic       A,
    output logic       B,
    output logic       overrun
);

    localparam prio_mode_e MODE = (ROUND_ROBIN != 0) ? PRIO_ROTATE : PRIO_FIXED;

    line_vec_t d_q;
    line_vec_t d_d;
    line_vec_t pending_q;
    line_vec_t pending_d;
    logic      valid_q;
    logic      valid_d;
    code_t     code_q;
    code_t     code_d;
    logic      overrun_q;
    logic      overrun_d;
    code_t     ptr_q;
    code_t     ptr_d;

    line_vec_t edge_det;
    line_vec_t grant;
    logic      slot_free;
    code_t     start_idx;
    logic      pick_found;
    code_t     pick_idx;

    prio_pick4 u_pick (
        .req   (pending_q),
        .start (start_idx),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        d_d       = D;
        edge_det  = D & ~d_q & {NUM_LINES{enable}};
        start_idx = (MODE == PRIO_ROTATE) ? ptr_q : TOP_INDEX;
        slot_free = ~valid_q | ready;

        grant   = '0;
        valid_d = valid_q;
        code_d  = code_q;
        ptr_d   = ptr_q;

        if (slot_free) begin
            if (pick_found) begin
                grant   = onehot(pick_idx);
                valid_d = 1'b1;
                code_d  = pick_idx;
                if (MODE == PRIO_ROTATE) begin
                    ptr_d = pick_idx - code_t'(1);
                end
            end else begin
                valid_d = 1'b0;
                code_d  = '0;
            end
        end

        // A fresh edge on a line being granted this cycle survives as a new event.
        pending_d = (pending_q & ~grant) | edge_det;
        overrun_d = overrun_q | (|(edge_det & pending_q & ~grant));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q       <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            overrun_q <= 1'b0;
            ptr_q     <= TOP_INDEX;
        end else begin
            d_q       <= d_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
            ptr_q     <= ptr_d;
        end
    end

    assign valid   = valid_q;
    assign A       = code_q[1];
    assign B       = code_q[0];
    assign overrun = overrun_q;

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Directed self-checking bench for encoder4_2_seq: one fixed-priority and
// one rotating-priority instance sharing clock and reset.
module tb_encoder4_2_seq;

    logic       clk;
    logic       rst;
    logic       en_fx, en_rr;
    logic [3:0] d_fx, d_rr;
    logic       rdy_fx, rdy_rr;
    logic       valid_fx, a_fx, b_fx, ovr_fx;
    logic       valid_rr, a_rr, b_rr, ovr_rr;

    int checks;
    int failures;

    wire [2:0] obs_fx = {valid_fx, a_fx, b_fx};
    wire [2:0] obs_rr = {valid_rr, a_rr, b_rr};

    encoder4_2_seq #(.ROUND_ROBIN(0)) dut_fx (
        .clk     (clk),
        .rst     (rst),
        .enable  (en_fx),
        .D       (d_fx),
        .ready   (rdy_fx),
        .valid   (valid_fx),
        .A       (a_fx),
        .B       (b_fx),
        .overrun (ovr_fx)
    );

    encoder4_2_seq #(.ROUND_ROBIN(1)) dut_rr (
        .clk     (clk),
        .rst     (rst),
        .enable  (en_rr),
        .D       (d_rr),
        .ready   (rdy_rr),
        .valid   (valid_rr),
        .A       (a_rr),
        .B       (b_rr),
        .overrun (ovr_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        d_fx   = 4'b0000;
        d_rr   = 4'b0000;
        en_fx  = 1'b1;
        en_rr  = 1'b1;
        rdy_fx = 1'b1;
        rdy_rr = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        d_fx   = 4'b1111;
        d_rr   = 4'b1111;
        en_fx  = 1'b1;
        en_rr  = 1'b1;
        rdy_fx = 1'b1;
        rdy_rr = 1'b1;
        #1;
        checks++;
        if ({obs_fx, ovr_fx} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_fx: got %b expected 0000", {obs_fx, ovr_fx});
        end
        checks++;
        if ({obs_rr, ovr_rr} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_rr: got %b expected 0000", {obs_rr, ovr_rr});
        end
        step();
        checks++;
        if ({obs_fx, ovr_fx} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_held_fx: got %b expected 0000", {obs_fx, ovr_fx});
        end
    endtask

    task automatic test_single_pulse();
        do_reset();
        d_fx = 4'b0100;
        step();
        checks++;
        if (obs_fx !== 3'b000) begin
            failures++;
            $display("[TB] FAIL single_latency: got %b expected 000", obs_fx);
        end
        d_fx = 4'b0000;
        step();
        checks++;
        if (obs_fx !== 3'b110) begin
            failures++;
            $display("[TB] FAIL single_code: got %b expected 110", obs_fx);
        end
        step();
        checks++;
        if (obs_fx !== 3'b000) begin
            failures++;
            $display("[TB] FAIL single_one_cycle: got %b expected 000", obs_fx);
        end
    endtask

    task automatic test_multi_fixed();
        logic [2:0] exp_seq [4] = '{3'b111, 3'b101, 3'b100, 3'b000};
        do_reset();
        d_fx = 4'b1011;
        step();
        d_fx = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_fx !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL multi_fixed[%0d]: got %b expected %b", i, obs_fx, exp_seq[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [5] = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b111};
        do_reset();
        d_rr = 4'b1111;
        step();
        d_rr = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_rr !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL round_robin[%0d]: got %b expected %b", i, obs_rr, exp_seq[i]);
            end
            d_rr = (i % 2 == 0) ? 4'b1111 : 4'b0000;
        end
        d_rr = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy_fx = 1'b0;
        d_fx   = 4'b0011;
        step();
        d_fx = 4'b0000;
        step();
        checks++;
        if (obs_fx !== 3'b101) begin
            failures++;
            $display("[TB] FAIL bp_first: got %b expected 101", obs_fx);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_fx !== 3'b101) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: got %b expected 101", i, obs_fx);
            end
        end
        rdy_fx = 1'b1;
        step();
        checks++;
        if (obs_fx !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bp_release: got %b expected 100", obs_fx);
        end
        step();
        checks++;
        if (obs_fx !== 3'b000) begin
            failures++;
            $display("[TB] FAIL bp_drained: got %b expected 000", obs_fx);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        rdy_fx = 1'b0;
        d_fx   = 4'b1000;
        step();
        d_fx = 4'b0000;
        step();
        d_fx = 4'b0100;
        step();
        checks++;
        if (ovr_fx !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_first_pulse: got %b expected 0", ovr_fx);
        end
        d_fx = 4'b0000;
        step();
        d_fx = 4'b0100;
        step();
        checks++;
        if (ovr_fx !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overrun_set: got %b expected 1", ovr_fx);
        end
        d_fx   = 4'b0000;
        rdy_fx = 1'b1;
        repeat (4) step();
        checks++;
        if ({obs_fx, ovr_fx} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL overrun_sticky: got %b expected 0001", {obs_fx, ovr_fx});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ovr_fx !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_rst_clear: got %b expected 0", ovr_fx);
        end
    endtask

    task automatic test_grant_coincide();
        do_reset();
        rdy_fx = 1'b0;
        d_fx   = 4'b1100;
        step();
        d_fx = 4'b0000;
        step();
        checks++;
        if (obs_fx !== 3'b111) begin
            failures++;
            $display("[TB] FAIL coincide_setup: got %b expected 111", obs_fx);
        end
        step();
        d_fx   = 4'b0100;
        rdy_fx = 1'b1;
        step();
        checks++;
        if ({obs_fx, ovr_fx} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL coincide_grant: got %b expected 1100", {obs_fx, ovr_fx});
        end
        d_fx = 4'b0000;
        step();
        checks++;
        if ({obs_fx, ovr_fx} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL coincide_reemit: got %b expected 1100", {obs_fx, ovr_fx});
        end
        step();
        checks++;
        if (obs_fx !== 3'b000) begin
            failures++;
            $display("[TB] FAIL coincide_drained: got %b expected 000", obs_fx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rdy_fx = 1'b0;
        d_fx   = 4'b1110;
        step();
        d_fx = 4'b0000;
        step();
        checks++;
        if (obs_fx !== 3'b111) begin
            failures++;
            $display("[TB] FAIL arst_setup: got %b expected 111", obs_fx);
        end
        #3;
        rst  = 1'b1;
        d_fx = 4'b0001;
        #1;
        checks++;
        if (obs_fx !== 3'b000) begin
            failures++;
            $display("[TB] FAIL arst_outputs: got %b expected 000", obs_fx);
        end
        checks++;
        if (dut_fx.pending_q !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL arst_pending: got %b expected 0000", dut_fx.pending_q);
        end
        step();
        step();
        rst    = 1'b0;
        rdy_fx = 1'b1;
        step();
        checks++;
        if (obs_fx !== 3'b000) begin
            failures++;
            $display("[TB] FAIL arst_latency: got %b expected 000", obs_fx);
        end
        step();
        checks++;
        if (obs_fx !== 3'b100) begin
            failures++;
            $display("[TB] FAIL arst_first_edge_event: got %b expected 100", obs_fx);
        end
        d_fx = 4'b0000;
    endtask

    task automatic test_enable();
        do_reset();
        en_fx = 1'b0;
        d_fx  = 4'b0010;
        step();
        d_fx = 4'b0000;
        step();
        step();
        checks++;
        if (obs_fx !== 3'b000) begin
            failures++;
            $display("[TB] FAIL enable_ignored: got %b expected 000", obs_fx);
        end
        en_fx = 1'b1;
        d_fx  = 4'b0010;
        step();
        d_fx = 4'b0000;
        step();
        checks++;
        if (obs_fx !== 3'b101) begin
            failures++;
            $display("[TB] FAIL enable_restored: got %b expected 101", obs_fx);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_pulse();
        test_multi_fixed();
        test_round_robin();
        test_backpressure();
        test_overrun();
        test_grant_coincide();
        test_async_reset();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder4_2_seq.md
ENCODER4_2_SEQ -- requirements
Module: encoder4_2_seq

Interface
REQ-001 SHALL have parameter: ROUND_ROBIN, 0, 0 = fixed priority (D[3] highest), 1 = rotating priority.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: enable  input  1  event-capture enable.
REQ-005 SHALL have port: D  input  4  request lines; index k maps to code k.
REQ-006 SHALL have port: ready  input  1  consumer accepts the current code.
REQ-007 SHALL have port: valid  output  1  A,B hold a valid code.
REQ-008 SHALL have port: A  output  1  code MSB.
REQ-009 SHALL have port: B  output  1  code LSB; the code is {A,B}.
REQ-010 SHALL have port: overrun  output  1  sticky flag: an event was lost.

Function
REQ-011 SHALL register D into d_q each clk; edge[k] = D[k] & ~d_q[k] & enable.
REQ-012 SHALL hold a 4-bit pending register; pending_next = (pending & ~grant) | edge.
REQ-013 SHALL set pending when edge and grant hit the same bit in one cycle: the new event survives and the old one is consumed.
REQ-014 SHALL set overrun when edge[k] occurs while pending[k]=1 and bit k is not granted that cycle; the flag stays set until rst.
REQ-015 SHALL treat the output slot as free when valid=0, or when valid=1 and ready=1.
REQ-016 SHALL, when the slot is free and pending≠0, select one index k, load {A,B}=k, set valid=1 and assert grant[k] for that cycle.
REQ-017 SHALL clear valid when the slot is free and pending=0.
REQ-018 SHALL hold valid, A and B stable while valid=1 and ready=0.
REQ-019 SHALL sustain a throughput of one code per cycle while ready=1 and pending≠0.
REQ-020 SHALL have a latency of 2 clk edges from D rising (sampled) to valid=1: edge n sets pending, edge n+1 loads the output.
REQ-021 SHALL ignore edges while enable=0 (d_q still tracks D); pending and output continue to drain.
REQ-022 SHALL, with ROUND_ROBIN=0, use the search order 3,2,1,0.
REQ-023 SHALL, with ROUND_ROBIN=1, keep a 2-bit pointer p and use the search order p, p-1, p-2, p-3 (mod 4).
REQ-024 SHALL, after a grant of k with ROUND_ROBIN=1, set p=(k-1) mod 4; p wraps 0 to 3.
REQ-025 SHALL drive A=0 and B=0 whenever valid=0.

Reset
REQ-026 SHALL, while rst=1, force asynchronously: d_q=0, pending=0, valid=0, A=0, B=0, overrun=0, p=3.
REQ-027 SHALL discard in-flight codes and pending events when rst asserts mid-operation; nothing is replayed after release.
REQ-028 SHALL treat D[k]=1 on the first edge after rst release as an event, because d_q resets to 0.

Structure
REQ-029 SHALL place the constants NUM_LINES=4, CODE_W=2 and the priority-mode encoding in the shared package encoder_pkg.
REQ-030 SHALL implement selection in one combinational sub-module prio_pick4 (inputs: pending, start index; outputs: found, index), reused by both modes.

Verification
REQ-031 SHALL cover this case: ready=1, fixed mode, D pulses 4'b0100 for 1 cycle -> valid=1 with {A,B}=2, exactly 2 edges later, for 1 cycle.
REQ-032 SHALL cover this case: fixed mode, ready=1, D=4'b1011 rising together -> codes 3,1,0 on consecutive cycles, then valid=0.
REQ-033 SHALL cover this case: ROUND_ROBIN=1, all four lines re-pulsed after each grant -> code sequence 3,2,1,0,3, with p wrapping.
REQ-034 SHALL cover this case: valid=1 with code 1, ready=0 for 5 cycles -> A,B,valid unchanged; ready=1 -> next pending code on the following edge.
REQ-035 SHALL cover this case: D[2] pulses twice while ready=0 and pending[2]=1 -> overrun=1, held until rst; the same pulse coinciding with a grant of 2 -> no overrun, code 2 emitted again.
REQ-036 SHALL cover this case: rst asserted mid-drain with pending=4'b0110 -> valid=0 and pending=0 immediately (asynchronously); D held at 4'b0001 through release -> code 0 emitted 2 edges after release.
